// File: rtl/mul_f32_pipe.sv
// mul_f32_pipe: 3-stage FP32 multiplier, FTZ, truncating, valid/ready.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/product.
module mul_f32_pipe #(
  parameter int WIDTH         = 32,
  parameter int EXPONENTWIDTH = 8,
  parameter int MANTISSAWIDTH = 23,
  parameter int BIAS          = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
);
  localparam int EW = EXPONENTWIDTH;
  localparam int MW = MANTISSAWIDTH;
  localparam int FW = MW + 1;
  localparam int PW = 2 * FW;
  localparam int SW = EW + 2;

  localparam logic [EW-1:0] EMAX = '1;
  localparam logic signed [SW-1:0] EBIAS = SW'(BIAS);
  localparam logic signed [SW-1:0] ONE = SW'(1);
  localparam logic signed [SW-1:0] ZERO = '0;
  localparam logic signed [SW-1:0] EOVF = {2'b00, EMAX};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;
  assign ea = a[WIDTH-2 -: EW];
  assign eb = b[WIDTH-2 -: EW];
  assign ma = a[MW-1:0];
  assign mb = b[MW-1:0];

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX);
  assign b_inf  = (eb == EMAX);
  assign a_nan  = a_inf && (ma != '0);
  assign b_nan  = b_inf && (mb != '0);

  logic signed [SW-1:0] esum_d;
  assign esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EBIAS;

  // stage 1
  logic                 v1, s1, z1, i1, n1;
  logic signed [SW-1:0] e1;
  logic [FW-1:0]        m1a, m1b;

  // stage 2
  logic                 v2, s2, z2, i2, n2;
  logic signed [SW-1:0] e2;
  logic [PW-1:0]        p2;

  logic [PW-1:0] p_d;
  assign p_d = {{FW{1'b0}}, m1a} * {{FW{1'b0}}, m1b};

  // stage 3 normalise/pack
  logic signed [SW-1:0] e3;
  logic [MW-1:0]        mant3;
  logic [WIDTH-1:0]     res;

  always_comb begin
    e3    = p2[PW-1] ? e2 + ONE : e2;
    mant3 = p2[PW-1] ? p2[PW-2 -: MW] : p2[PW-3 -: MW];
    res   = {s2, e3[EW-1:0], mant3};
    if (n2)
      res = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
    else if (i2)
      res = {s2, EMAX, {MW{1'b0}}};
    else if (z2)
      res = {s2, {EW{1'b0}}, {MW{1'b0}}};
    else if (e3 >= EOVF)
      res = {s2, EMAX, {MW{1'b0}}};
    else if (e3 <= ZERO)
      res = {s2, {EW{1'b0}}, {MW{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1        <= 1'b0;
      z1        <= 1'b0;
      i1        <= 1'b0;
      n1        <= 1'b0;
      e1        <= '0;
      m1a       <= '0;
      m1b       <= '0;
      v2        <= 1'b0;
      s2        <= 1'b0;
      z2        <= 1'b0;
      i2        <= 1'b0;
      n2        <= 1'b0;
      e2        <= '0;
      p2        <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1  <= a[WIDTH-1] ^ b[WIDTH-1];
        e1  <= esum_d;
        m1a <= {!a_zero, ma};
        m1b <= {!b_zero, mb};
        z1  <= a_zero || b_zero;
        i1  <= a_inf || b_inf;
        n1  <= a_nan || b_nan
            || (a_inf && b_zero) || (b_inf && a_zero);
      end
      v2 <= v1;
      if (v1) begin
        s2 <= s1;
        e2 <= e1;
        p2 <= p_d;
        z2 <= z1;
        i2 <= i1;
        n2 <= n1;
      end
      out_valid <= v2;
      if (v2) product <= res;
    end
  end

endmodule

// File: doc/mul_f32_pipe.md
Name: mul_f32_pipe

Overview:
Three-stage pipelined IEEE-754 single-precision multiplier in the PE datapath. Sits directly upstream of add_f32: its products feed the adder's operand input for multiply-accumulate. Uses a valid/ready handshake on both sides so the PE controller can stall it without losing data. Denormals are flushed to zero and results are truncated; there is no rounding.

Parameters:
WIDTH, 32, total float width
EXPONENTWIDTH, 8, exponent field width
MANTISSAWIDTH, 23, stored mantissa width (hidden bit excluded)
BIAS, 127, exponent bias

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands a, b valid this cycle
in_ready  output  1  multiplier accepts operands this cycle
a  input  WIDTH  operand A {sign, exp, mant}
b  input  WIDTH  operand B {sign, exp, mant}
out_valid  output  1  product valid
out_ready  input  1  consumer (add_f32 operand register) accepts product
product  output  WIDTH  A*B {sign, exp, mant}

Behaviour:
- Reset (rst_n low, async): all stage valid bits = 0; out_valid = 0; product = 0; in_ready = 1 once rst_n is high. Reset asserted mid-operation discards all in-flight operands.
- Transfers: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Pipeline advance: advance = !v3 || out_ready, where v3 is the stage-3 valid bit. in_ready = advance (combinational).
- When advance = 0, all three stages hold their contents and valid bits. Bubbles are not collapsed during a stall.
- Latency: 3 cycles from input transfer to out_valid when there is no stall. Throughput: 1 result per cycle.
- Stage 1:
  - Register sign = a[31] ^ b[31].
  - Register esum = ea + eb - BIAS as a 10-bit signed value.
  - Register mantissas with hidden bit: {ea!=0, ma} and {eb!=0, mb}.
  - Register flags: zero flag (either exp==0), inf flag (either exp==255), nan flag (inf with the other operand zero, or either operand a NaN, i.e. exp==255 and mant!=0).
- Stage 2: register the 48-bit product of the two 24-bit mantissas; pass sign, esum and flags along.
- Stage 3 (normalise and pack):
  - If p[47]: mant = p[46:24], e = esum + 1. Else: mant = p[45:23], e = esum.
  - Truncate; no rounding.
- Stage 3 priority order:
  - nan -> 0x7FC00000.
  - inf -> {sign, 8'hFF, 0}.
  - zero -> {sign, 0, 0}.
  - e >= 255 -> {sign, 8'hFF, 0} (overflow to infinity).
  - e <= 0 -> {sign, 0, 0} (underflow flush).
  - otherwise -> {sign, e[7:0], mant}.
- product is registered and holds its value while out_valid && !out_ready.
- Simultaneous input accept and output drain in the same cycle is legal and required for full throughput.

Test Plan:
- Reset: rst_n=0 asynchronously mid-stream, with no clock edge during reset -> out_valid=0 and product=0 immediately. After release, in_ready=1 and no stale result ever appears.
- Basic: a=0x3FC00000 (1.5), b=0x40200000 (2.5), in_valid pulse, out_ready=1 -> out_valid high exactly 3 cycles later with product=0x40700000 (3.75). Also a=0xC0000000, b=0x40400000 -> 0xC0C00000 (-6).
- Specials:
  - 0x00000000 * 0x40A00000 -> 0x00000000.
  - 0x7F000000 * 0x40000000 -> 0x7F800000 (overflow).
  - 0x00800000 * 0x3F000000 -> 0x00000000 (underflow).
  - 0x7F800000 * 0x00000000 -> 0x7FC00000 (NaN).
- Throughput: 8 back-to-back operand pairs with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 3, results in input order.
- Backpressure: stream 5 pairs and drop out_ready for 4 cycles while results are pending:
  - in_ready falls in the same cycle out_ready drops (when v3=1).
  - product stays stable while stalled.
  - No result is lost or duplicated; all 5 results match golden values in order.
- Chain check: feed products into add_f32 (1.5*2.5 + 0.25) -> adder sum 0x40800000 (4.0).
